instr_mem_loader: RTL

- Initiator side of the instruction/data memory preload port: drives instr_en, mem_adr and mem_in.
- Receives a byte stream from a host link over a valid/ready handshake, for example a UART receiver.
- Assembles bytes little-endian into 32-bit words and writes them to consecutive word addresses starting at 0.
- Holds the CPU stopped (cpu_run low) until the whole image is written.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_word_assembler.sv | 35 +++
 rtl/instr_mem_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction memory loader.
// Imported by the loader top and its byte assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int CNT_W = 2;
  localparam int WC_W  = 32;

endpackage

// File: rtl/byte_word_assembler.sv
// Little-endian byte to 32-bit word assembler.
// word is valid together with word_full, in the cycle of the 4th byte.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        strobe,
  input  logic        clr,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [CNT_W-1:0] cnt;
  logic [23:0]      sr;

  assign word      = {din, sr};
  assign word_full = strobe && (cnt == CNT_W'(3));

  // Shift bytes in from the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (strobe) begin
      cnt <= cnt + CNT_W'(1);
      sr  <= {din, sr[23:8]};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed byte image into instruction memory.
// Keeps the CPU halted until every word has been written.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int MEM_LENGTH = 100,
  parameter int TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        instr_en,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_in,
  output logic        cpu_run,
  output logic        done,
  output logic        err
);

  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [31:0] TMO_LIM =
    TMO_EN ? 32'(TIMEOUT - 1) : 32'd0;
  localparam logic [WC_W-1:0] MAX_N =
    WC_W'(MEM_LENGTH);

  state_t state, state_n;

  logic [WC_W-1:0] n_q, n_d;
  logic [WC_W-1:0] idx_q, idx_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [31:0]     adr_d, data_d;
  logic [31:0]     word;
  logic            word_full;
  logic            xfer, clr, tmo_hit;

  assign xfer    = rx_valid & rx_ready;
  assign clr     = (state == IDLE) ||
                   (state == DONE) ||
                   (state == ERR);
  assign tmo_hit = TMO_EN && !xfer &&
                   (tmo_q == TMO_LIM);

  byte_word_assembler u_asm (
    .clk       (clk),
    .res       (res),
    .strobe    (xfer),
    .clr       (clr),
    .din       (rx_data),
    .word      (word),
    .word_full (word_full)
  );

  // Next state, counters and the values the output registers load.
  always_comb begin
    state_n = state;
    n_d     = n_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    adr_d   = mem_adr;
    data_d  = mem_in;
    unique case (state)
      IDLE: begin
        if (start) state_n = HDR;
      end
      HDR: begin
        if (word_full) begin
          n_d   = word;
          idx_d = '0;
          if (word == '0)
            state_n = DONE;
          else if (word > MAX_N)
            state_n = ERR;
          else
            state_n = DATA;
        end else if (xfer) begin
          tmo_d = '0;
        end else if (tmo_hit) begin
          state_n = ERR;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      DATA: begin
        if (word_full) begin
          state_n = WRITE;
          adr_d   = 32'(idx_q);
          data_d  = word;
        end else if (xfer) begin
          tmo_d = '0;
        end else if (tmo_hit) begin
          state_n = ERR;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      WRITE: begin
        idx_d = idx_q + WC_W'(1);
        if (idx_d == n_q)
          state_n = DONE;
        else
          state_n = DATA;
      end
      DONE: begin
        if (start) state_n = HDR;
      end
      ERR: begin
        if (start) state_n = HDR;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      n_q   <= '0;
      idx_q <= '0;
      tmo_q <= '0;
    end else begin
      state <= state_n;
      n_q   <= n_d;
      idx_q <= idx_d;
      tmo_q <= tmo_d;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rx_ready <= 1'b0;
      instr_en <= 1'b0;
      mem_adr  <= '0;
      mem_in   <= '0;
      cpu_run  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rx_ready <= (state_n == HDR) ||
                  (state_n == DATA);
      instr_en <= (state_n == WRITE);
      mem_adr  <= adr_d;
      mem_in   <= data_d;
      cpu_run  <= (state_n == DONE);
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
    end
  end

endmodule
